axis_video_monitor: RTL and testbench

- Synthesizable AXI4-Stream video sink and protocol monitor for pixel-generator streams.
- Generates tready in one of four runtime-selectable modes, with a PRBS backpressure source.
- Checks SOF (tuser) and EOL (tlast) placement against a parametrised frame geometry, along with valid timeout and hold-stability.
- Reports sticky error flags, a saturating error count, and frame/line positions for on-chip or simulation use.

---
 rtl/axis_video_monitor.sv | 119 +++++++++++
 tb/tb_axis_video_monitor.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/axis_video_monitor.sv
// axis_video_monitor: AXI4-Stream video sink with ready generation and SOF/EOL/timeout/stability checking
module axis_video_monitor #(
  parameter int DATA_W = 32,
  parameter int X_SIZE = 480,
  parameter int Y_SIZE = 640,
  parameter int TIMEOUT = 1000,
  parameter logic [32:0] RND_SEED = 33'd1246504138,
  parameter int CNT_W = 16,
  localparam int XW = X_SIZE > 1 ? $clog2(X_SIZE) : 1,
  localparam int YW = Y_SIZE > 1 ? $clog2(Y_SIZE) : 1,
  localparam int TW = $clog2(TIMEOUT + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        mode,
  input  logic              clear_errors,
  input  logic [DATA_W-1:0] s_tdata,
  input  logic              s_tvalid,
  input  logic              s_tuser,
  input  logic              s_tlast,
  output logic              s_tready,
  output logic              locked,
  output logic [XW-1:0]     x_pos,
  output logic [YW-1:0]     y_pos,
  output logic [CNT_W-1:0]  frame_count,
  output logic              frame_done,
  output logic [5:0]        err_flags,
  output logic [CNT_W-1:0]  err_count
);
  typedef enum logic {SYNC, ACTIVE} state_t;
  state_t state_q, state_d;
  logic [32:0] prbs_q, prbs_d;
  logic rdy_q, rdy_d, fd_q, fd_d, stall_q, stall_d;
  logic [XW-1:0] x_q, x_d, ex;
  logic [YW-1:0] y_q, y_d, ey;
  logic [CNT_W-1:0] fc_q, fc_d, ec_q, ec_d;
  logic [5:0] ef_q, ef_d, ev;
  logic [3:0] ev_chk;
  logic ev_to, ev_un, beat, x_end, y_end, wrap;
  logic [TW-1:0] to_q, to_d, to_inc;
  logic [DATA_W+1:0] hold_q, hold_d;
  always_comb begin
    beat = s_tvalid && rdy_q;
    ex = s_tuser ? '0 : x_q;
    ey = s_tuser ? '0 : y_q;
    x_end = ex == XW'(X_SIZE - 1);
    y_end = ey == YW'(Y_SIZE - 1);
    wrap = s_tlast || x_end;
    ev_chk = '0;
    state_d = state_q;
    x_d = x_q;
    y_d = y_q;
    fc_d = fc_q;
    fd_d = 1'b0;
    if (beat && !s_tuser && x_q == '0 && y_q == '0) begin
      ev_chk[0] = 1'b1;
      state_d = SYNC;
    end else if (beat) begin
      state_d = ACTIVE;
      ev_chk[1] = s_tuser && (x_q != '0 || y_q != '0);
      ev_chk[2] = x_end && !s_tlast;
      ev_chk[3] = s_tlast && !x_end;
      fc_d = s_tuser ? fc_q + CNT_W'(1) : fc_q;
      x_d = wrap ? '0 : ex + XW'(1);
      y_d = wrap ? (y_end ? '0 : ey + YW'(1)) : ey;
      fd_d = wrap && y_end;
    end
  end
  always_comb begin
    prbs_d = {prbs_q[31:0], prbs_q[32] ^ ~prbs_q[19]};
    rdy_d = mode == 2'd0 ? 1'b1 : mode == 2'd1 ? prbs_q[32] : mode == 2'd2 ? (s_tvalid && !rdy_q) : 1'b0;
    to_inc = to_q + TW'(1);
    ev_to = !s_tvalid && to_inc == TW'(TIMEOUT);
    to_d = (s_tvalid || ev_to) ? '0 : to_inc;
    hold_d = {s_tdata, s_tuser, s_tlast};
    stall_d = s_tvalid && !rdy_q;
    ev_un = stall_q && (!s_tvalid || hold_d != hold_q);
    ev = {ev_un, ev_to, ev_chk};
    ef_d = (clear_errors ? 6'd0 : ef_q) | ev;
    ec_d = clear_errors ? CNT_W'(|ev) : ((|ev) && !(&ec_q)) ? ec_q + CNT_W'(1) : ec_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SYNC;
      prbs_q <= RND_SEED;
      rdy_q <= 1'b0;
      fd_q <= 1'b0;
      stall_q <= 1'b0;
      x_q <= '0;
      y_q <= '0;
      fc_q <= '0;
      ec_q <= '0;
      ef_q <= '0;
      to_q <= '0;
      hold_q <= '0;
    end else begin
      state_q <= state_d;
      prbs_q <= prbs_d;
      rdy_q <= rdy_d;
      fd_q <= fd_d;
      stall_q <= stall_d;
      x_q <= x_d;
      y_q <= y_d;
      fc_q <= fc_d;
      ec_q <= ec_d;
      ef_q <= ef_d;
      to_q <= to_d;
      hold_q <= hold_d;
    end
  end
  assign s_tready = rdy_q;
  assign locked = state_q == ACTIVE;
  assign x_pos = x_q;
  assign y_pos = y_q;
  assign frame_count = fc_q;
  assign frame_done = fd_q;
  assign err_flags = ef_q;
  assign err_count = ec_q;
endmodule

// File: tb/tb_axis_video_monitor.sv
// tb_axis_video_monitor: scoreboard bench for axis_video_monitor with a 4x2 frame and TIMEOUT=10
module tb_axis_video_monitor;
  localparam logic [32:0] SEED = 33'd1246504138;
  logic clk = 0, rst = 1, clear_errors = 0;
  logic [1:0] mode = 0;
  logic [31:0] s_tdata = 0;
  logic s_tvalid = 0, s_tuser = 0, s_tlast = 0;
  logic s_tready, locked, frame_done;
  logic [1:0] x_pos;
  logic [0:0] y_pos;
  logic [15:0] frame_count, err_count;
  logic [5:0] err_flags;
  typedef struct {int x; int y; int lock; int fc; int ef; int ec;} exp_t;
  exp_t sbq[$];
  logic rq[$];
  int checks = 0, errors = 0, fd_cnt = 0, ec_exp = 0;
  logic [5:0] ef_exp = 0;
  logic chk_rdy = 0, rec = 0, mutate = 0;
  logic [32:0] pm = SEED;
  time t0, t1;
  axis_video_monitor #(.DATA_W(32), .X_SIZE(4), .Y_SIZE(2), .TIMEOUT(10), .RND_SEED(SEED), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .mode(mode), .clear_errors(clear_errors),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tuser(s_tuser), .s_tlast(s_tlast),
    .s_tready(s_tready), .locked(locked), .x_pos(x_pos), .y_pos(y_pos),
    .frame_count(frame_count), .frame_done(frame_done), .err_flags(err_flags), .err_count(err_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask
  initial forever begin
    logic acc;
    exp_t e;
    @(negedge clk);
    #1 acc = s_tvalid && s_tready && !rst;
    @(posedge clk);
    #1;
    if (acc && sbq.size() == 0) chk("scoreboard_underflow", 0, 1);
    else if (acc) begin
      e = sbq.pop_front();
      chk("x_pos", int'(x_pos), e.x);
      chk("y_pos", int'(y_pos), e.y);
      chk("locked", int'(locked), e.lock);
      chk("frame_count", int'(frame_count), e.fc);
      chk("err_flags", int'(err_flags), e.ef);
      chk("err_count", int'(err_count), e.ec);
    end
  end
  initial forever begin
    @(posedge clk);
    #1;
    if (frame_done) fd_cnt++;
    if (chk_rdy) chk("prbs_ready", int'(s_tready), rst ? 0 : int'(pm[32]));
    pm = rst ? SEED : {pm[31:0], pm[32] ^ ~pm[19]};
  end
  initial forever begin
    @(negedge clk);
    #1;
    if (rec) rq.push_back(s_tready);
  end
  initial begin
    #1_000_000;
    chk("watchdog", 0, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  task automatic do_reset();
    rst = 1;
    s_tvalid = 0;
    s_tuser = 0;
    s_tlast = 0;
    clear_errors = 0;
    repeat (2) @(negedge clk);
    rst = 0;
    ef_exp = 0;
    ec_exp = 0;
    fd_cnt = 0;
  endtask
  task automatic send(input logic [31:0] d, input logic u, input logic l, input int ex, input int ey, input int el, input int efc);
    int n;
    s_tdata = d;
    s_tvalid = 1;
    s_tuser = u;
    s_tlast = l;
    #1 n = 0;
    while (!s_tready && n < 200) begin
      @(negedge clk);
      if (mutate) begin
        s_tdata = ~s_tdata;
        mutate = 0;
        ef_exp[5] = 1;
        ec_exp = ec_exp + 1;
      end
      #1 n++;
    end
    if (!s_tready) begin
      chk("ready_wait", 0, 1);
      s_tvalid = 0;
      @(negedge clk);
    end else begin
      sbq.push_back('{ex, ey, el, efc, int'(ef_exp), ec_exp});
      @(negedge clk);
    end
  endtask
  initial begin
    @(posedge clk);
    #1 chk("reset_outputs_zero", int'(|{s_tready, locked, x_pos, y_pos, frame_count, frame_done, err_flags, err_count}), 0);
    @(negedge clk);
    // two clean frames
    do_reset();
    for (int i = 0; i < 16; i++) send(i, i % 8 == 0, i % 4 == 3, (i + 1) % 4, ((i + 1) / 4) % 2, 1, i / 8 + 1);
    chk("t1_frame_done_pulses", fd_cnt, 2);
    chk("t1_locked", int'(locked), 1);
    chk("t1_err_count", int'(err_count), 0);
    // missing SOF before a clean frame
    do_reset();
    for (int k = 0; k < 3; k++) begin
      ef_exp = 1;
      ec_exp = k + 1;
      send(100 + k, 0, 0, 0, 0, 0, 0);
    end
    for (int i = 0; i < 8; i++) send(i, i == 0, i % 4 == 3, (i + 1) % 4, ((i + 1) / 4) % 2, 1, 1);
    chk("t2_err_flags", int'(err_flags), 1);
    chk("t2_err_count", int'(err_count), 3);
    // missing then early EOL
    do_reset();
    send(0, 1, 0, 1, 0, 1, 1);
    send(1, 0, 0, 2, 0, 1, 1);
    send(2, 0, 0, 3, 0, 1, 1);
    ef_exp = 6'b000100;
    ec_exp = 1;
    send(3, 0, 0, 0, 1, 1, 1);
    send(4, 0, 0, 1, 1, 1, 1);
    ef_exp = 6'b001100;
    ec_exp = 2;
    send(5, 0, 1, 0, 0, 1, 1);
    send(6, 1, 0, 1, 0, 1, 2);
    chk("t3_frame_done_pulses", fd_cnt, 1);
    // random ready, one data change during a stall
    mode = 1;
    chk_rdy = 1;
    do_reset();
    for (int i = 0; i < 1000; i++) begin
      if (i == 100) mutate = 1;
      send(32'h1000 + i, i % 8 == 0, i % 4 == 3, (i + 1) % 4, ((i + 1) / 4) % 2, 1, i / 8 + 1);
    end
    chk_rdy = 0;
    chk("t4_mutation_applied", int'(mutate), 0);
    chk("t4_err_flags", int'(err_flags), 32);
    chk("t4_err_count", int'(err_count), 1);
    chk("t4_frame_count", int'(frame_count), 125);
    // valid timeout then clear
    mode = 0;
    do_reset();
    repeat (9) @(posedge clk);
    #1 chk("t5_no_timeout_at_9", int'(err_count), 0);
    @(posedge clk);
    #1 chk("t5_timeout_at_10", int'(err_count), 1);
    chk("t5_flags_at_10", int'(err_flags), 16);
    repeat (15) @(posedge clk);
    #1 chk("t5_count_at_25", int'(err_count), 2);
    chk("t5_flags_at_25", int'(err_flags), 16);
    @(negedge clk);
    clear_errors = 1;
    @(posedge clk);
    #1 chk("t5_cleared_flags", int'(err_flags), 0);
    chk("t5_cleared_count", int'(err_count), 0);
    @(negedge clk);
    clear_errors = 0;
    // ready-after-valid and mid-line reset
    mode = 2;
    do_reset();
    rec = 1;
    send(32'hA0, 1, 0, 1, 0, 1, 1);
    t0 = $time;
    send(32'hA1, 0, 0, 2, 0, 1, 1);
    t1 = $time;
    send(32'hA2, 0, 0, 3, 0, 1, 1);
    rec = 0;
    chk("t6_beat_spacing", int'(t1 - t0), 20);
    chk("t6_ready_samples", rq.size() >= 4, 1);
    if (rq.size() >= 4) begin
      chk("t6_ready0", int'(rq[0]), 0);
      chk("t6_ready1", int'(rq[1]), 1);
      chk("t6_ready2", int'(rq[2]), 0);
      chk("t6_ready3", int'(rq[3]), 1);
    end
    rst = 1;
    s_tvalid = 0;
    @(posedge clk);
    #1 chk("t6_reset_outputs_zero", int'(|{s_tready, locked, x_pos, y_pos, frame_count, frame_done, err_flags, err_count}), 0);
    @(negedge clk);
    rst = 0;
    ef_exp = 1;
    ec_exp = 1;
    send(32'h55, 0, 0, 0, 0, 0, 0);
    chk("t6_scoreboard_drained", sbq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
